// File: rtl/aes_rc_pkg.sv
// Shared AES round-constant definitions used by the forward and reverse
// round-constant sequencers: the constant type, the sequencer state encoding
// and the GF(2^8) xtime step together with its exact inverse.
package aes_rc_pkg;

    typedef logic [7:0] rc_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rc_seq_state_e;

    // Reduction constant for x^8 = x^4 + x^3 + x + 1 when multiplying by x.
    localparam rc_t RC_POLY     = 8'h1b;
    // Correction constant when dividing by x: 0x8d = (0x1b >> 1) | 0x80.
    localparam rc_t RC_INV_POLY = 8'h8d;

    // Multiply by x in GF(2^8): the forward round-constant step.
    function automatic rc_t rc_xtime(input rc_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? RC_POLY : 8'h00);
    endfunction

    // Divide by x in GF(2^8): exact inverse of rc_xtime for every 8-bit input.
    function automatic rc_t rc_inv_xtime(input rc_t x);
        return {1'b0, x[7:1]} ^ (x[0] ? RC_INV_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/prev_round_const_seq.sv
// Reverse round-constant sequencer. Pops one seed constant from the input
// FIFO, then pushes NUM_RC constants to the output FIFO, stepping the
// constant backwards through the schedule with rc_inv_xtime between pushes.
// Output back-pressure freezes the burst; new seeds wait in the input FIFO
// until the current burst has finished.
module prev_round_const_seq
    import aes_rc_pkg::*;
#(
    parameter int NUM_RC = 10,
    parameter int CW     = $clog2(NUM_RC + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    in_rc,
    output logic          in_rc_rd,
    input  logic          in_rc_empty,
    output logic [7:0]    out_rc,
    output logic [CW-1:0] out_rc_idx,
    output logic          out_rc_last,
    output logic          out_rc_wr,
    input  logic          out_rc_full,
    output logic          busy
);

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_RC - 1);

    rc_seq_state_e state_q, state_d;
    rc_t           cur_q,   cur_d;
    logic [CW-1:0] idx_q,   idx_d;
    logic          last_w;

    // FIFO strobes and status are direct decodes of the current state.
    assign last_w      = (state_q == RUN) && (idx_q == LAST_IDX);
    assign in_rc_rd    = (state_q == IDLE) && !in_rc_empty;
    assign out_rc_wr   = (state_q == RUN) && !out_rc_full;
    assign out_rc      = cur_q;
    assign out_rc_idx  = idx_q;
    assign out_rc_last = last_w;
    assign busy        = (state_q == RUN);

    // Next-state logic: load a seed in IDLE, step backwards on each push in RUN.
    always_comb begin
        // NOTE: every output of this block gets a hold default first, so no
        // path through the case can leave a value unassigned and infer a latch.
        state_d = state_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_rc_rd) begin
                    cur_d   = in_rc;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (out_rc_wr) begin
                    if (last_w) begin
                        // The final constant stays visible on out_rc.
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cur_d = rc_inv_xtime(cur_q);
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!reset) begin
            state_q <= IDLE;
            cur_q   <= 8'h00;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_prev_round_const_seq.sv
// Self-checking bench for prev_round_const_seq. Three instances cover
// NUM_RC = 10, 3 and 1. Stimulus pushes hand-computed expected constants
// into per-instance queues; negedge monitors pop and compare on every push.
module tb_prev_round_const_seq;
    import aes_rc_pkg::*;

    typedef struct {
        rc_t rc;
        int  idx;
        bit  last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to timestamp strobes.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: NUM_RC = 10 ----------------
    rc_t        in_rc_a;
    logic       in_rc_rd_a, in_rc_empty_a;
    rc_t        out_rc_a;
    logic [3:0] out_rc_idx_a;
    logic       out_rc_last_a, out_rc_wr_a, out_rc_full_a, busy_a;

    prev_round_const_seq #(.NUM_RC(10)) dut_a (
        .clock(clk), .reset(rst_n),
        .in_rc(in_rc_a), .in_rc_rd(in_rc_rd_a), .in_rc_empty(in_rc_empty_a),
        .out_rc(out_rc_a), .out_rc_idx(out_rc_idx_a), .out_rc_last(out_rc_last_a),
        .out_rc_wr(out_rc_wr_a), .out_rc_full(out_rc_full_a), .busy(busy_a)
    );

    // ---------------- instance B: NUM_RC = 3 ----------------
    rc_t        in_rc_b;
    logic       in_rc_rd_b, in_rc_empty_b;
    rc_t        out_rc_b;
    logic [1:0] out_rc_idx_b;
    logic       out_rc_last_b, out_rc_wr_b, out_rc_full_b, busy_b;

    prev_round_const_seq #(.NUM_RC(3)) dut_b (
        .clock(clk), .reset(rst_n),
        .in_rc(in_rc_b), .in_rc_rd(in_rc_rd_b), .in_rc_empty(in_rc_empty_b),
        .out_rc(out_rc_b), .out_rc_idx(out_rc_idx_b), .out_rc_last(out_rc_last_b),
        .out_rc_wr(out_rc_wr_b), .out_rc_full(out_rc_full_b), .busy(busy_b)
    );

    // ---------------- instance C: NUM_RC = 1 ----------------
    rc_t        in_rc_c;
    logic       in_rc_rd_c, in_rc_empty_c;
    rc_t        out_rc_c;
    logic [0:0] out_rc_idx_c;
    logic       out_rc_last_c, out_rc_wr_c, out_rc_full_c, busy_c;

    prev_round_const_seq #(.NUM_RC(1)) dut_c (
        .clock(clk), .reset(rst_n),
        .in_rc(in_rc_c), .in_rc_rd(in_rc_rd_c), .in_rc_empty(in_rc_empty_c),
        .out_rc(out_rc_c), .out_rc_idx(out_rc_idx_c), .out_rc_last(out_rc_last_c),
        .out_rc_wr(out_rc_wr_c), .out_rc_full(out_rc_full_c), .busy(busy_c)
    );

    // Hand-computed reverse schedules (each entry is rc_inv_xtime of the previous).
    rc_t seq_36 [10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    rc_t seq_6c [10] = '{8'h6c, 8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    rc_t seq_02 [10] = '{8'h02, 8'h01, 8'h8d, 8'hcb, 8'he8, 8'h74, 8'h3a, 8'h1d, 8'h83, 8'hcc};
    rc_t seq_01 [3]  = '{8'h01, 8'h8d, 8'hcb};

    exp_t exp_a[$], exp_b[$], exp_c[$];
    rc_t  seed_q_a[$];
    rc_t  got_b[$], got_c[$];
    int   rd_cyc_a[$], push_cyc_a[$];
    bit   rd_seen_a = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: timed out waiting for the DUT (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic refresh_a();
        in_rc_empty_a = (seed_q_a.size() == 0);
        in_rc_a       = in_rc_empty_a ? 8'h00 : seed_q_a[0];
    endtask

    task automatic push_seed_a(input rc_t s);
        seed_q_a.push_back(s);
        refresh_a();
    endtask

    task automatic expect_a(input rc_t seq [10]);
        for (int i = 0; i < 10; i++) exp_a.push_back('{rc: seq[i], idx: i, last: (i == 9)});
    endtask

    task automatic clear_log_a();
        rd_cyc_a.delete();
        push_cyc_a.delete();
    endtask

    task automatic wait_done_a(input string name, input int budget);
        int k = 0;
        while ((exp_a.size() != 0 || busy_a) && k < budget) begin
            tick();
            k++;
        end
        if (exp_a.size() != 0 || busy_a) timeout(name);
    endtask

    task automatic check_reset_outputs_a(input string tag);
        check({tag, "_in_rc_rd"},    in_rc_rd_a,    0);
        check({tag, "_out_rc_wr"},   out_rc_wr_a,   0);
        check({tag, "_out_rc"},      out_rc_a,      8'h00);
        check({tag, "_out_rc_idx"},  out_rc_idx_a,  0);
        check({tag, "_out_rc_last"}, out_rc_last_a, 0);
        check({tag, "_busy"},        busy_a,        0);
    endtask

    // Input FIFO model for A: the popped head leaves the queue just after the edge.
    always @(posedge clk) begin
        #1;
        if (rd_seen_a) begin
            if (seed_q_a.size() != 0) void'(seed_q_a.pop_front());
            rd_seen_a = 1'b0;
            refresh_a();
        end
    end

    // Monitor A: timestamp strobes and score each push against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (in_rc_rd_a) begin
            rd_seen_a = 1'b1;
            rd_cyc_a.push_back(cyc);
        end
        if (out_rc_wr_a) begin
            push_cyc_a.push_back(cyc);
            if (exp_a.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL a_unexpected_push: got 0x%0h, expected no push (cycle %0d)", out_rc_a, cyc);
            end else begin
                e = exp_a.pop_front();
                check("a_rc",   out_rc_a,      e.rc);
                check("a_idx",  out_rc_idx_a,  e.idx);
                check("a_last", out_rc_last_a, e.last);
            end
        end
    end

    // Monitor B: score each push and keep it for the re-encode check.
    always @(negedge clk) begin
        exp_t e;
        if (out_rc_wr_b) begin
            got_b.push_back(out_rc_b);
            if (exp_b.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL b_unexpected_push: got 0x%0h, expected no push (cycle %0d)", out_rc_b, cyc);
            end else begin
                e = exp_b.pop_front();
                check("b_rc",   out_rc_b,      e.rc);
                check("b_idx",  out_rc_idx_b,  e.idx);
                check("b_last", out_rc_last_b, e.last);
            end
        end
    end

    // Monitor C: score each push of the single-constant instance.
    always @(negedge clk) begin
        exp_t e;
        if (out_rc_wr_c) begin
            got_c.push_back(out_rc_c);
            if (exp_c.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL c_unexpected_push: got 0x%0h, expected no push (cycle %0d)", out_rc_c, cyc);
            end else begin
                e = exp_c.pop_front();
                check("c_rc",   out_rc_c,      e.rc);
                check("c_idx",  out_rc_idx_c,  e.idx);
                check("c_last", out_rc_last_c, e.last);
            end
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_miss);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        refresh_a();
        out_rc_full_a = 1'b0;
        in_rc_b = 8'h00; in_rc_empty_b = 1'b1; out_rc_full_b = 1'b0;
        in_rc_c = 8'h00; in_rc_empty_c = 1'b1; out_rc_full_c = 1'b0;

        // Reset state.
        #1;
        check_reset_outputs_a("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Seed 0x36, never full: ten consecutive pushes, one pop one cycle earlier.
        clear_log_a();
        expect_a(seq_36);
        push_seed_a(8'h36);
        wait_done_a("t1_done", 40);
        check("t1_rd_count",   rd_cyc_a.size(),   1);
        check("t1_push_count", push_cyc_a.size(), 10);
        if (rd_cyc_a.size() == 1 && push_cyc_a.size() == 10) begin
            check("t1_first_push_latency", push_cyc_a[0] - rd_cyc_a[0], 1);
            check("t1_burst_span",         push_cyc_a[9] - push_cyc_a[0], 9);
        end
        check("t1_out_rc_holds_last", out_rc_a, 8'h01);

        // NUM_RC=3, seed 0x01, then re-encode each push forward.
        exp_b.push_back('{rc: 8'h01, idx: 0, last: 1'b0});
        exp_b.push_back('{rc: 8'h8d, idx: 1, last: 1'b0});
        exp_b.push_back('{rc: 8'hcb, idx: 2, last: 1'b1});
        in_rc_b = 8'h01;
        in_rc_empty_b = 1'b0;
        k = 0;
        while (!in_rc_rd_b && k < 10) begin @(negedge clk); k++; end
        if (!in_rc_rd_b) timeout("t2_pop");
        tick();
        in_rc_empty_b = 1'b1;
        k = 0;
        while ((exp_b.size() != 0 || busy_b) && k < 20) begin tick(); k++; end
        if (exp_b.size() != 0 || busy_b) timeout("t2_done");
        check("t2_push_count", got_b.size(), 3);
        if (got_b.size() == 3) begin
            for (int i = 1; i < 3; i++) check("t2_reencode", rc_xtime(got_b[i]), seq_01[i-1]);
        end

        // Back-pressure on burst cycles 2..4: 0x80 held, no push, sequence intact.
        clear_log_a();
        expect_a(seq_36);
        push_seed_a(8'h36);
        k = 0;
        while (!busy_a && k < 10) begin tick(); k++; end
        if (!busy_a) timeout("t3_start");
        tick();
        for (int j = 0; j < 3; j++) begin
            tick();
            out_rc_full_a = 1'b1;
            @(negedge clk);
            check("t3_hold_rc",   out_rc_a,     8'h80);
            check("t3_hold_idx",  out_rc_idx_a, 2);
            check("t3_no_push",   out_rc_wr_a,  0);
        end
        tick();
        out_rc_full_a = 1'b0;
        wait_done_a("t3_done", 40);
        check("t3_push_count", push_cyc_a.size(), 10);
        if (push_cyc_a.size() == 10) check("t3_burst_span", push_cyc_a[9] - push_cyc_a[0], 12);

        // Two seeds back to back: second pop right after first burst's last push.
        clear_log_a();
        expect_a(seq_36);
        expect_a(seq_6c);
        push_seed_a(8'h36);
        push_seed_a(8'h6c);
        wait_done_a("t4_done", 80);
        check("t4_rd_count",   rd_cyc_a.size(),   2);
        check("t4_push_count", push_cyc_a.size(), 20);
        if (rd_cyc_a.size() == 2 && push_cyc_a.size() == 20) begin
            check("t4_second_pop_gap",  rd_cyc_a[1] - push_cyc_a[9], 1);
            check("t4_second_push_lat", push_cyc_a[10] - rd_cyc_a[1], 1);
        end

        // Reset at push 4: outputs clear at once, nothing until a new seed.
        clear_log_a();
        expect_a(seq_36);
        push_seed_a(8'h36);
        k = 0;
        while (push_cyc_a.size() < 4 && k < 20) begin tick(); k++; end
        if (push_cyc_a.size() < 4) timeout("t5_reach_push4");
        rst_n = 1'b0;
        #1;
        check_reset_outputs_a("t5_async");
        exp_a.delete();
        tick();
        tick();
        rst_n = 1'b1;
        clear_log_a();
        repeat (5) tick();
        check("t5_idle_rd_count",   rd_cyc_a.size(),   0);
        check("t5_idle_push_count", push_cyc_a.size(), 0);
        expect_a(seq_02);
        push_seed_a(8'h02);
        wait_done_a("t5_done", 40);
        check("t5_push_count", push_cyc_a.size(), 10);

        // NUM_RC=1, seed 0xaa: one push flagged last with index 0, then idle.
        exp_c.push_back('{rc: 8'haa, idx: 0, last: 1'b1});
        in_rc_c = 8'haa;
        in_rc_empty_c = 1'b0;
        k = 0;
        while (!in_rc_rd_c && k < 10) begin @(negedge clk); k++; end
        if (!in_rc_rd_c) timeout("t6_pop");
        tick();
        in_rc_empty_c = 1'b1;
        k = 0;
        while ((exp_c.size() != 0 || busy_c) && k < 10) begin tick(); k++; end
        if (exp_c.size() != 0 || busy_c) timeout("t6_done");
        check("t6_push_count", got_c.size(), 1);
        check("t6_idle_busy",  busy_c,       0);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
